// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op classes, ALU control codes,
// RV32M funct3 codes, forwarding selects and the MDU FSM state type.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_mop(input logic [1:0] aluop, input logic [6:0] funct7);
        return (aluop == ALUOP_RTYPE) && (funct7 == F7_MEXT);
    endfunction

endpackage

// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit: issue-time operand capture, fixed-latency multiply
// and a radix-2 restoring divider, sequenced by an IDLE/MUL/DIV/DONE FSM.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            negq_q, negq_d, negr_q, negr_d;

    // Divide operates on magnitudes; signs are reapplied when the result is read.
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   div_shift, div_diff;

    assign a_neg = ~funct3_i[0] & op_a_i[XLEN-1];
    assign b_neg = ~funct3_i[0] & op_b_i[XLEN-1];
    assign a_mag = a_neg ? -op_a_i : op_a_i;
    assign b_mag = b_neg ? -op_b_i : op_b_i;

    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        stall_o = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    f3_d    = funct3_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    quo_d   = a_mag;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    if (funct3_i[2])
                        state_d = MDU_DIV;
                    else
                        state_d = (MUL_LAT == 1) ? MDU_DONE : MDU_MUL;
                end
            end
            MDU_MUL: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_q == MUL_LAST) state_d = MDU_DONE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            MDU_DIV: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                end else begin
                    stall_o = 1'b1;
                    quo_d   = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
                    rem_d   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    if (cnt_q == DIV_LAST) state_d = MDU_DONE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    // Sign-extending to 2*XLEN lets one unsigned multiply serve all four variants.
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_res, quo_fix, rem_fix, div_res;

    assign a_sgn = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
    assign b_sgn = (f3_q == F3_MULH);
    assign a_ext = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign b_ext = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod  = a_ext * b_ext;
    assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign quo_fix = (b_q == '0) ? '1  : (negq_q ? -quo_q : quo_q);
    assign rem_fix = (b_q == '0) ? a_q : (negr_q ? -rem_q : rem_q);
    assign div_res = f3_q[1] ? rem_fix : quo_fix;

    assign done_o   = (state_q == MDU_DONE);
    assign result_o = f3_q[2] ? div_res : mul_res;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, ALUSrc mux, ALU control, ALU, branch adder and
// the ex_mdu instance. Optional stall-cycle counter built when EX_STALL_CNT_EN is defined.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_ex,
    input  logic            flush_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] reg_data1_ex,
    input  logic [XLEN-1:0] reg_data2_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [6:0]      funct7_ex,
    input  logic [1:0]      aluop_ex,
    input  logic            alusrc_ex,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] alu_data_wb,
    input  logic [XLEN-1:0] alu_out_mem,
    output logic            zero_ex,
    output logic [XLEN-1:0] alu_out_ex,
    output logic [XLEN-1:0] pc_branch_ex,
    output logic [XLEN-1:0] reg_data2_final,
    output logic            stall_ex,
    output logic [31:0]     stall_cycles
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, mdu_res;
    logic [3:0]      alu_ctrl;
    logic            mdu_done;

    always_comb begin
        fwd_a = '0;
        case (forward_a)
            FWD_REG:  fwd_a = reg_data1_ex;
            FWD_WB:   fwd_a = alu_data_wb;
            FWD_MEM:  fwd_a = alu_out_mem;
            default:  fwd_a = '0;
        endcase
    end

    always_comb begin
        fwd_b = '0;
        case (forward_b)
            FWD_REG:  fwd_b = reg_data2_ex;
            FWD_WB:   fwd_b = alu_data_wb;
            FWD_MEM:  fwd_b = alu_out_mem;
            default:  fwd_b = '0;
        endcase
    end

    assign op_b            = alusrc_ex ? imm_ex : fwd_b;
    assign reg_data2_final = fwd_b;
    assign pc_branch_ex    = pc_ex + imm_ex;

    // I-type has no SUB; funct7[5] still picks SRAI over SRLI.
    always_comb begin
        alu_ctrl = ALU_CTRL_ADD;
        case (aluop_ex)
            ALUOP_ADD: alu_ctrl = ALU_CTRL_ADD;
            ALUOP_SUB: alu_ctrl = ALU_CTRL_SUB;
            default: begin
                case (funct3_ex)
                    3'd0: alu_ctrl = (aluop_ex == ALUOP_RTYPE && funct7_ex[5]) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
                    3'd1: alu_ctrl = ALU_CTRL_SLL;
                    3'd2: alu_ctrl = ALU_CTRL_SLT;
                    3'd3: alu_ctrl = ALU_CTRL_SLTU;
                    3'd4: alu_ctrl = ALU_CTRL_XOR;
                    3'd5: alu_ctrl = funct7_ex[5] ? ALU_CTRL_SRA : ALU_CTRL_SRL;
                    3'd6: alu_ctrl = ALU_CTRL_OR;
                    default: alu_ctrl = ALU_CTRL_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_CTRL_ADD:  alu_res = fwd_a + op_b;
            ALU_CTRL_SUB:  alu_res = fwd_a - op_b;
            ALU_CTRL_SLL:  alu_res = fwd_a << op_b[SHW-1:0];
            ALU_CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            ALU_CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
            ALU_CTRL_XOR:  alu_res = fwd_a ^ op_b;
            ALU_CTRL_SRL:  alu_res = fwd_a >> op_b[SHW-1:0];
            ALU_CTRL_SRA:  alu_res = $signed(fwd_a) >>> op_b[SHW-1:0];
            ALU_CTRL_OR:   alu_res = fwd_a | op_b;
            ALU_CTRL_AND:  alu_res = fwd_a & op_b;
            default:       alu_res = '0;
        endcase
    end

    ex_mdu #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT)
    ) u_mdu (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .start_i  (valid_ex && is_mop(aluop_ex, funct7_ex)),
        .flush_i  (flush_ex),
        .funct3_i (funct3_ex),
        .op_a_i   (fwd_a),
        .op_b_i   (fwd_b),
        .stall_o  (stall_ex),
        .done_o   (mdu_done),
        .result_o (mdu_res)
    );

    assign alu_out_ex = mdu_done ? mdu_res : alu_res;
    assign zero_ex    = (alu_out_ex == '0);

`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_ex ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: randomized ALU ops and RV32M ops against an
// arithmetic reference model, plus flush, mid-op reset and stall-counter scenarios.
module tb_ex_stage_md;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_ex, flush_ex, alusrc_ex;
    logic [31:0] imm_ex, reg_data1_ex, reg_data2_ex, pc_ex, alu_data_wb, alu_out_mem;
    logic [2:0]  funct3_ex;
    logic [6:0]  funct7_ex;
    logic [1:0]  aluop_ex, forward_a, forward_b;
    logic        zero_ex, stall_ex;
    logic [31:0] alu_out_ex, pc_branch_ex, reg_data2_final, stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .valid_ex        (valid_ex),
        .flush_ex        (flush_ex),
        .imm_ex          (imm_ex),
        .reg_data1_ex    (reg_data1_ex),
        .reg_data2_ex    (reg_data2_ex),
        .pc_ex           (pc_ex),
        .funct3_ex       (funct3_ex),
        .funct7_ex       (funct7_ex),
        .aluop_ex        (aluop_ex),
        .alusrc_ex       (alusrc_ex),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .alu_data_wb     (alu_data_wb),
        .alu_out_mem     (alu_out_mem),
        .zero_ex         (zero_ex),
        .alu_out_ex      (alu_out_ex),
        .pc_branch_ex    (pc_branch_ex),
        .reg_data2_final (reg_data2_final),
        .stall_ex        (stall_ex),
        .stall_cycles    (stall_cycles)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r, wb, mem);
        case (sel)
            2'd0: return r;
            2'd1: return wb;
            2'd2: return mem;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a, b);
        int sh;
        sh = int'(b[4:0]);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        case (f3)
            3'd0: return (op == 2'b10 && f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, b);
        longint sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; p = 64'(q); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = ua / ub; p = 64'(q); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; p = 64'(q); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; p = 64'(q); return p[31:0];
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        valid_ex = 0; flush_ex = 0; alusrc_ex = 0;
        aluop_ex = 2'b00; funct3_ex = 0; funct7_ex = 0;
        forward_a = 0; forward_b = 0;
        imm_ex = 0; reg_data1_ex = 0; reg_data2_ex = 0; pc_ex = 0;
        alu_data_wb = 0; alu_out_mem = 0;
    endtask

    task automatic drive_add(input logic [31:0] a, b);
        valid_ex = 1; flush_ex = 0; alusrc_ex = 0; aluop_ex = 2'b10;
        funct3_ex = 3'd0; funct7_ex = 7'h00; forward_a = 0; forward_b = 0;
        reg_data1_ex = a; reg_data2_ex = b;
    endtask

    task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, b);
        valid_ex = 1; flush_ex = 0; alusrc_ex = 0; aluop_ex = 2'b10;
        funct3_ex = f3; funct7_ex = 7'h01; forward_a = 0; forward_b = 0;
        reg_data1_ex = a; reg_data2_ex = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        drive_add(32'd1, 32'd2);
        #1;
        n_tests++;
        if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_ex); end
        n_tests++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
        n_tests++;
        if (alu_out_ex !== 32'd3) begin n_fail++; $display("FAIL reset_comb got=%h exp=3", alu_out_ex); end
        @(posedge clk); #1;
        reset_n = 1;
        drive_idle();
    endtask

    task automatic test_fwd_add();
        @(posedge clk); #1;
        drive_idle();
        valid_ex = 1; forward_a = 2'b10; alu_out_mem = 32'd5; reg_data2_ex = 32'd3;
        #1;
        n_tests++;
        if (alu_out_ex !== 32'd8 || stall_ex !== 1'b0) begin
            n_fail++; $display("FAIL fwd_add got=%h stall=%b exp=8 stall=0", alu_out_ex, stall_ex);
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b, e;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            valid_ex = 1'($urandom);
            flush_ex = 0;
            aluop_ex = 2'($urandom);
            funct3_ex = 3'($urandom);
            funct7_ex = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            alusrc_ex = 1'($urandom);
            forward_a = 2'($urandom);
            forward_b = 2'($urandom);
            imm_ex = $urandom; reg_data1_ex = $urandom; reg_data2_ex = $urandom;
            pc_ex = $urandom; alu_data_wb = $urandom; alu_out_mem = $urandom;
            if (i % 7 == 0) reg_data2_ex = reg_data1_ex;
            a = fwd_ref(forward_a, reg_data1_ex, alu_data_wb, alu_out_mem);
            b = alusrc_ex ? imm_ex : fwd_ref(forward_b, reg_data2_ex, alu_data_wb, alu_out_mem);
            e = alu_ref(aluop_ex, funct3_ex, funct7_ex, a, b);
            #1;
            n_tests++;
            if (alu_out_ex !== e || zero_ex !== (e == 0)) begin
                n_fail++; $display("FAIL alu[%0d] got=%h z=%b exp=%h", i, alu_out_ex, zero_ex, e);
            end
            n_tests++;
            if (pc_branch_ex !== pc_ex + imm_ex || reg_data2_final !== fwd_ref(forward_b, reg_data2_ex, alu_data_wb, alu_out_mem)) begin
                n_fail++; $display("FAIL side[%0d] pcb=%h rd2=%h", i, pc_branch_ex, reg_data2_final);
            end
            n_tests++;
            if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL alu_stall[%0d] got=%b exp=0", i, stall_ex); end
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Issues one M-op, scrambles operand inputs while stalled, checks result in DONE.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, b);
        int lat;
        logic [31:0] e;
        lat = f3[2] ? XLEN + 1 : MUL_LAT;
        e = mdu_ref(f3, a, b);
        @(posedge clk); #1;
        drive_mop(f3, a, b);
        #1;
        n_tests++;
        if (stall_ex !== 1'b1) begin n_fail++; $display("FAIL mop_issue_stall f3=%0d got=%b exp=1", f3, stall_ex); end
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            reg_data1_ex = $urandom; reg_data2_ex = $urandom;
            alu_data_wb = $urandom; alu_out_mem = $urandom;
            #1;
            n_tests++;
            if (stall_ex !== 1'b1) begin n_fail++; $display("FAIL mop_stall f3=%0d cyc=T+%0d got=%b exp=1", f3, k, stall_ex); end
        end
        @(posedge clk); #2;
        n_tests++;
        if (stall_ex !== 1'b0 || alu_out_ex !== e || zero_ex !== (e == 0)) begin
            n_fail++;
            $display("FAIL mop_result f3=%0d a=%h b=%h got=%h z=%b stall=%b exp=%h", f3, a, b, alu_out_ex, zero_ex, stall_ex, e);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_mdu_directed();
        run_mop(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_mop(3'd5, 32'd100, 32'd7);
        run_mop(3'd7, 32'd100, 32'd7);
        run_mop(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_mop(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_mop(3'd4, 32'd5, 32'd0);
        run_mop(3'd6, 32'd5, 32'd0);
        run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mop(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_mop(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_mdu_random();
        logic [31:0] b;
        for (int i = 0; i < 16; i++) begin
            b = (i % 5 == 4) ? 32'd0 : $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 28);
            run_mop(3'($urandom), $urandom, b);
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        drive_mop(3'd4, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) @(posedge clk);
        #1;
        flush_ex = 1;
        #1;
        n_tests++;
        if (stall_ex !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall_ex); end
        @(posedge clk); #1;
        drive_add(32'd20, 32'd22);
        #1;
        n_tests++;
        if (stall_ex !== 1'b0 || alu_out_ex !== 32'd42) begin
            n_fail++; $display("FAIL flush_next got=%h stall=%b exp=2a stall=0", alu_out_ex, stall_ex);
        end
        @(posedge clk); #1;
        drive_idle();
        run_mop(3'd0, 32'd6, 32'd9);
    endtask

    task automatic test_reset_midop(input logic [2:0] f3, input int at);
        @(posedge clk); #1;
        drive_mop(f3, 32'd77, 32'd5);
        for (int k = 1; k <= at; k++) @(posedge clk);
        #1;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        drive_idle();
        #1;
        n_tests++;
        if (stall_ex !== 1'b0 || stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_midop f3=%0d stall=%b cnt=%0d exp stall=0 cnt=0", f3, stall_ex, stall_cycles);
        end
        @(posedge clk); #1;
        drive_add(32'd3, 32'd4);
        #1;
        n_tests++;
        if (stall_ex !== 1'b0 || alu_out_ex !== 32'd7) begin
            n_fail++; $display("FAIL reset_after got=%h stall=%b exp=7 stall=0", alu_out_ex, stall_ex);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_stall_count();
        logic [31:0] e;
`ifdef EX_STALL_CNT_EN
        e = 32'(XLEN + 1);
`else
        e = 32'd0;
`endif
        @(posedge clk); #1;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        run_mop(3'd5, 32'd100, 32'd7);
        #1;
        n_tests++;
        if (stall_cycles !== e) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, e); end
    endtask

    initial begin
        drive_idle();
        reset_n = 0;
        test_reset();
        test_fwd_add();
        test_alu_random();
        test_mdu_directed();
        test_mdu_random();
        test_flush();
        test_reset_midop(3'd0, 1);
        test_reset_midop(3'd5, 5);
        test_stall_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
